// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line plus FIFO read port of the UART receiver.
//   slave  : receiver side (takes rx_in / rx_ready_in, drives head entry,
//            flags, busy and level).
//   master : consumer side (drives rx_in / rx_ready_in, observes the rest).
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          rx_in;
    logic                          rx_ready_in;
    logic                          rx_valid_out;
    logic [DATA_BITS-1:0]          rx_data_out;
    logic                          rx_perr_out;
    logic                          rx_ferr_out;
    logic                          rx_overrun_out;
    logic                          rx_busy_out;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;

    modport slave (
        input  rx_in, rx_ready_in,
        output rx_valid_out, rx_data_out, rx_perr_out, rx_ferr_out,
               rx_overrun_out, rx_busy_out, fifo_level_out
    );

    modport master (
        output rx_in, rx_ready_in,
        input  rx_valid_out, rx_data_out, rx_perr_out, rx_ferr_out,
               rx_overrun_out, rx_busy_out, fifo_level_out
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (configurable width / parity / stop bits)
// feeding a small FIFO with a valid/ready read port.
//   clk_in    : system clock
//   rst_in_n  : synchronous active-low reset
//   bus       : uart_rx_fifo_if.slave -- rx_in serial line, rx_ready_in pop,
//               head entry {rx_data_out, rx_perr_out, rx_ferr_out},
//               rx_valid_out, rx_overrun_out pulse, rx_busy_out, fifo_level_out
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 142,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk_in,
    input  logic          rst_in_n,
    uart_rx_fifo_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID_CNT   = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);
    localparam logic [AW:0]   FULL_LVL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 perr;
        logic                 ferr;
    } entry_t;

    state_t               state;
    logic [1:0]           sync;
    logic                 rx_sync;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;
    logic                 busy;

    assign rx_sync = sync[1];

    // Receive FSM. Every sample point is a counter terminal count; the start
    // bit is checked at mid-bit so all later samples land mid-bit too.
    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            sync  <= 2'b11;
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            sync <= {sync[0], bus.rx_in};
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == MID_CNT) begin
                        cnt  <= '0;
                        idx  <= '0;
                        perr <= 1'b0;
                        ferr <= 1'b0;
                        if (!rx_sync) begin
                            state <= DATA;
                        end else begin
                            // line went back high: a glitch, not a start bit
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        // LSB first: after DATA_BITS shifts bit 0 is the first bit
                        shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
                        if (idx == LAST_BIT) begin
                            idx   <= '0;
                            state <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        perr  <= (^shreg) ^ rx_sync ^ ODD;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt  <= '0;
                        ferr <= ferr | ~rx_sync;
                        // leave right after the last sample so an early start
                        // bit can still be caught from IDLE
                        if (idx == LAST_STOP) begin
                            state <= PUSH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO
    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overrun;
    logic          valid;
    logic          full;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    entry_t        head;

    assign valid    = (count != '0);
    assign full     = (count == FULL_LVL);
    assign push_req = (state == PUSH);
    assign pop      = valid & bus.rx_ready_in;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push_ok  = push_req & (~full | pop);
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{data: shreg, perr: perr, ferr: ferr};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req & full & ~pop;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // head fields are gated so an empty FIFO (and reset) shows all zeros
    assign bus.rx_valid_out   = valid;
    assign bus.rx_data_out    = valid ? head.data : '0;
    assign bus.rx_perr_out    = valid & head.perr;
    assign bus.rx_ferr_out    = valid & head.ferr;
    assign bus.rx_overrun_out = overrun;
    assign bus.rx_busy_out    = busy;
    assign bus.fifo_level_out = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: four receivers with CLKS_PER_BIT = 16, FIFO_DEPTH = 4:
//   0: 8N1   1: 8E1   2: 8O1   3: 8N2
// Table-driven frame vectors plus hand-written latency, glitch, overrun
// and mid-frame reset sequences.
module tb_uart_rx_fifo;
    localparam int CPB = 16;
    localparam int ND  = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [ND-1:0]       rx_v = '1;
    logic [ND-1:0]       rdy = '0;
    logic [ND-1:0]       vld, perr, ferr, ovr, busy;
    logic [ND-1:0][7:0]  dat;
    logic [ND-1:0][2:0]  lvl;
    int                  ovr_cnt [ND];
    int                  n_chk = 0;
    int                  n_fail = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < ND; k++) begin : g
        uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_if ();
        uart_rx_fifo #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS(8),
            .PARITY_MODE(k == 1 ? 1 : (k == 2 ? 2 : 0)),
            .STOP_BITS(k == 3 ? 2 : 1),
            .FIFO_DEPTH(4)
        ) dut (
            .clk_in(clk),
            .rst_in_n(rst_n),
            .bus(bus_if)
        );
        assign bus_if.rx_in       = rx_v[k];
        assign bus_if.rx_ready_in = rdy[k];
        assign vld[k]  = bus_if.rx_valid_out;
        assign dat[k]  = bus_if.rx_data_out;
        assign perr[k] = bus_if.rx_perr_out;
        assign ferr[k] = bus_if.rx_ferr_out;
        assign ovr[k]  = bus_if.rx_overrun_out;
        assign busy[k] = bus_if.rx_busy_out;
        assign lvl[k]  = bus_if.fifo_level_out;

        always @(posedge clk) begin
            if (!rst_n) ovr_cnt[k] <= 0;
            else if (ovr[k]) ovr_cnt[k] <= ovr_cnt[k] + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // line bits in transmit order: start, data LSB first, [parity], stop(s)
    function automatic logic [15:0] mk(input logic [7:0] d, input int has_par,
                                       input logic p, input logic s1, input logic s2);
        logic [15:0] b;
        int n;
        b = '1;
        b[0] = 1'b0;
        b[8:1] = d;
        n = 9;
        if (has_par != 0) begin
            b[n] = p;
            n++;
        end
        b[n] = s1;
        b[n+1] = s2;
        return b;
    endfunction

    // all tasks start and end 1 time unit after a rising edge
    task automatic drive_bits(input int s, input logic [15:0] b, input int nb);
        for (int i = 0; i < nb; i++) begin
            rx_v[s] = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // The last bit is sampled 11 edges after it starts, so the PUSH cycle
    // is the 12th cycle of that bit; ready can be raised exactly there.
    task automatic send_frame(input int s, input logic [15:0] b, input int nb,
                              input bit ready_in_push);
        drive_bits(s, b, nb - 1);
        rx_v[s] = b[nb-1];
        repeat (11) @(posedge clk);
        #1;
        if (ready_in_push) rdy[s] = 1'b1;
        @(posedge clk);
        #1;
        rdy[s] = 1'b0;
        repeat (CPB - 12) @(posedge clk);
        #1;
        rx_v[s] = 1'b1;
    endtask

    task automatic pop(input int s);
        rdy[s] = 1'b1;
        @(posedge clk);
        #1;
        rdy[s] = 1'b0;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] d;
        int         has_par;
        logic       p;
        int         nstop;
        logic       s1;
        logic       s2;
        logic       eperr;
        logic       eferr;
    } vec_t;

    vec_t vt [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, o;
        vt[0] = '{1, 8'h03, 1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b0}; // even, par 1 -> err
        vt[1] = '{1, 8'h03, 1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // even, par 0 ok
        vt[2] = '{2, 8'h03, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // odd, par 1 ok
        vt[3] = '{2, 8'h03, 1, 1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b0}; // odd, par 0 -> err
        vt[4] = '{0, 8'h5A, 0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b1}; // stop 0 -> ferr
        vt[5] = '{3, 8'hC3, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1}; // 2nd stop 0
        vt[6] = '{3, 8'h96, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0}; // 2 good stops
        vt[7] = '{0, 8'hFF, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8] = '{1, 8'h80, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0}; // even, one 1 + par 1

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", vld[0], 0);
        chk("reset level", lvl[0], 0);
        chk("reset busy", busy[0], 0);
        chk("reset data", dat[0], 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single frame 0xA5 with exact latency
        drive_bits(0, mk(8'hA5, 0, 1'b0, 1'b1, 1'b1), 9);
        rx_v[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        chk("a5 push-cycle valid", vld[0], 0);
        chk("a5 push-cycle busy", busy[0], 1);
        @(posedge clk);
        #1;
        chk("a5 valid", vld[0], 1);
        chk("a5 data", dat[0], 8'hA5);
        chk("a5 perr", perr[0], 0);
        chk("a5 ferr", ferr[0], 0);
        chk("a5 level", lvl[0], 1);
        chk("a5 busy", busy[0], 0);
        repeat (4) @(posedge clk);
        #1;
        chk("a5 held", dat[0], 8'hA5);
        pop(0);
        chk("a5 pop level", lvl[0], 0);
        chk("a5 pop valid", vld[0], 0);
        pop(0);
        chk("empty pop level", lvl[0], 0);

        // start glitch
        rx_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("glitch busy", busy[0], 1);
        repeat (20) @(posedge clk);
        #1;
        chk("glitch busy drop", busy[0], 0);
        chk("glitch valid", vld[0], 0);
        chk("glitch level", lvl[0], 0);

        // table vectors
        for (int i = 0; i < 9; i++) begin
            s = vt[i].sel;
            send_frame(s, mk(vt[i].d, vt[i].has_par, vt[i].p, vt[i].s1, vt[i].s2),
                       10 + vt[i].has_par + (vt[i].nstop - 1), 1'b0);
            repeat (20) @(posedge clk);
            #1;
            chk($sformatf("v%0d valid", i), vld[s], 1);
            chk($sformatf("v%0d data", i), dat[s], vt[i].d);
            chk($sformatf("v%0d perr", i), perr[s], vt[i].eperr);
            chk($sformatf("v%0d ferr", i), ferr[s], vt[i].eferr);
            chk($sformatf("v%0d level", i), lvl[s], 1);
            pop(s);
            chk($sformatf("v%0d pop level", i), lvl[s], 0);
        end

        // five frames, no reader: one dropped with overrun
        o = ovr_cnt[0];
        for (int d = 1; d <= 5; d++) send_frame(0, mk(8'(d), 0, 1'b0, 1'b1, 1'b1), 10, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("ovr pulses", ovr_cnt[0] - o, 1);
        chk("ovr level", lvl[0], 4);
        for (int d = 1; d <= 4; d++) begin
            chk($sformatf("ovr drain %0d", d), dat[0], d);
            pop(0);
        end
        chk("ovr drained level", lvl[0], 0);

        // same, but pop during the fifth PUSH cycle
        o = ovr_cnt[0];
        for (int d = 1; d <= 5; d++) send_frame(0, mk(8'(d), 0, 1'b0, 1'b1, 1'b1), 10, d == 5);
        repeat (5) @(posedge clk);
        #1;
        chk("popfull pulses", ovr_cnt[0] - o, 0);
        chk("popfull level", lvl[0], 4);
        for (int d = 2; d <= 5; d++) begin
            chk($sformatf("popfull drain %0d", d), dat[0], d);
            pop(0);
        end
        chk("popfull drained level", lvl[0], 0);

        // reset mid-DATA with two entries queued
        send_frame(0, mk(8'h11, 0, 1'b0, 1'b1, 1'b1), 10, 1'b0);
        send_frame(0, mk(8'h22, 0, 1'b0, 1'b1, 1'b1), 10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset level", lvl[0], 2);
        drive_bits(0, mk(8'h77, 0, 1'b0, 1'b1, 1'b1), 4);
        chk("pre-reset busy", busy[0], 1);
        rx_v[0] = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid reset level", lvl[0], 0);
        chk("mid reset valid", vld[0], 0);
        chk("mid reset busy", busy[0], 0);
        chk("mid reset data", dat[0], 0);
        chk("mid reset ferr", ferr[0], 0);
        chk("mid reset ovr", ovr[0], 0);
        repeat (5) @(posedge clk);
        #1;
        send_frame(0, mk(8'h3C, 0, 1'b0, 1'b1, 1'b1), 10, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("3c valid", vld[0], 1);
        chk("3c data", dat[0], 8'h3C);
        chk("3c ferr", ferr[0], 0);
        chk("3c level", lvl[0], 1);
        pop(0);
        chk("3c pop level", lvl[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
